// File: rtl/loop_key_pkg.sv
// rtl/loop_key_pkg.sv - keypad scancodes, hold-FSM states and digit decode helper
package loop_key_pkg;

  localparam logic [8:0] KEY_0     = 9'h070;
  localparam logic [8:0] KEY_1     = 9'h069;
  localparam logic [8:0] KEY_2     = 9'h072;
  localparam logic [8:0] KEY_3     = 9'h07A;
  localparam logic [8:0] KEY_4     = 9'h06B;
  localparam logic [8:0] KEY_5     = 9'h073;
  localparam logic [8:0] KEY_6     = 9'h074;
  localparam logic [8:0] KEY_7     = 9'h06C;
  localparam logic [8:0] KEY_8     = 9'h075;
  localparam logic [8:0] KEY_9     = 9'h07D;
  localparam logic [8:0] KEY_PLUS  = 9'h079;
  localparam logic [8:0] KEY_MINUS = 9'h07B;

  typedef enum logic [1:0] {
    HOLD_IDLE   = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } hold_state_e;

  // Returns {is_digit, digit}; digit is 0 when the code is not a keypad digit.
  function automatic logic [4:0] decode_digit(input logic [8:0] code);
    case (code)
      KEY_0:   return {1'b1, 4'd0};
      KEY_1:   return {1'b1, 4'd1};
      KEY_2:   return {1'b1, 4'd2};
      KEY_3:   return {1'b1, 4'd3};
      KEY_4:   return {1'b1, 4'd4};
      KEY_5:   return {1'b1, 4'd5};
      KEY_6:   return {1'b1, 4'd6};
      KEY_7:   return {1'b1, 4'd7};
      KEY_8:   return {1'b1, 4'd8};
      KEY_9:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/loop_param_selector_if.sv
// rtl/loop_param_selector_if.sv - keyboard/sequencer side bus of the loop parameter selector
interface loop_param_selector_if #(
  parameter int VAL_W = 3
);
  logic [511:0]     key_down;
  logic [8:0]       last_change;
  logic             key_valid;
  logic             loop_boundary;
  logic [VAL_W-1:0] value;
  logic [VAL_W-1:0] target;
  logic             pending;
  logic             changed;

  modport master (
    output key_down, last_change, key_valid, loop_boundary,
    input  value, target, pending, changed
  );

  modport slave (
    input  key_down, last_change, key_valid, loop_boundary,
    output value, target, pending, changed
  );
endinterface

// File: rtl/key_repeat_timer.sv
// rtl/key_repeat_timer.sv - hold-to-auto-repeat FSM emitting one-cycle step pulses
module key_repeat_timer
  import loop_key_pkg::*;
#(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic held,
  output logic step
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  localparam logic [1:0] S_IDLE   = HOLD_IDLE;
  localparam logic [1:0] S_DELAY  = HOLD_DELAY;
  localparam logic [1:0] S_REPEAT = HOLD_REPEAT;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             terminal;

  // Terminal count of the current phase; a new press (start) or release suppresses the step.
  always_comb begin
    terminal = ((state == S_DELAY) && (cnt == DELAY_LAST)) ||
               ((state == S_REPEAT) && (cnt == PERIOD_LAST));
    step     = terminal && held && !start;
  end

  // Hold FSM: a press restarts the delay, release drops to idle, terminal count re-arms the period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (start) begin
      state <= S_DELAY;
      cnt   <= '0;
    end else if (state != S_IDLE) begin
      if (!held) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else if (terminal) begin
        state <= S_REPEAT;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/loop_param_selector.sv
// rtl/loop_param_selector.sv - keyboard-driven bounded loop parameter; LOOP_PARAM_SYNC_EN stages commits to loop boundaries
module loop_param_selector
  import loop_key_pkg::*;
#(
  parameter int VAL_W         = 3,
  parameter int MIN_VAL       = 2,
  parameter int MAX_VAL       = 6,
  parameter int RESET_VAL     = 3,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  loop_param_selector_if.slave bus
);

  logic             press;
  logic [4:0]       dig;
  logic             digit_ok;
  logic             plus_press;
  logic             minus_press;
  logic             start;
  logic             up;
  logic             held;
  logic             step;
  logic             step_up;
  logic [VAL_W-1:0] target_q;
  logic [VAL_W-1:0] target_next;
  logic [VAL_W-1:0] value_q;
  logic [VAL_W-1:0] value_next;
  logic             changed_q;

  // Decode the keyboard strobe into digit and step presses; releases only matter via key_down.
  always_comb begin
    press       = bus.key_valid && bus.key_down[bus.last_change];
    dig         = decode_digit(bus.last_change);
    digit_ok    = press && dig[4] && (int'(dig[3:0]) >= MIN_VAL) && (int'(dig[3:0]) <= MAX_VAL);
    plus_press  = press && (bus.last_change == KEY_PLUS);
    minus_press = press && (bus.last_change == KEY_MINUS);
    start       = plus_press || minus_press;
    held        = bus.key_down[up ? KEY_PLUS : KEY_MINUS] && !digit_ok;
    step_up     = start ? plus_press : up;
  end

  // Remember which step key owns the current hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up <= 1'b1;
    end else if (start) begin
      up <= plus_press;
    end
  end

  key_repeat_timer #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .held  (held),
    .step  (step)
  );

  // Next target: digit entry wins, otherwise a saturating step from a press or auto-repeat.
  always_comb begin
    target_next = target_q;
    if (digit_ok) begin
      target_next = VAL_W'(dig[3:0]);
    end else if (start || step) begin
      if (step_up) begin
        if (target_q < VAL_W'(MAX_VAL)) target_next = target_q + VAL_W'(1);
      end else begin
        if (target_q > VAL_W'(MIN_VAL)) target_next = target_q - VAL_W'(1);
      end
    end
  end

`ifdef LOOP_PARAM_SYNC_EN
  // Commit the pre-update target only at a loop wrap.
  always_comb begin
    value_next  = bus.loop_boundary ? target_q : value_q;
    bus.pending = (target_q != value_q);
  end
`else
  logic unused_boundary;
  // Committed value follows the target on the same edge.
  always_comb begin
    value_next      = target_next;
    bus.pending     = 1'b0;
    unused_boundary = bus.loop_boundary;
  end
`endif

  // Parameter registers and the change pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q  <= VAL_W'(RESET_VAL);
      value_q   <= VAL_W'(RESET_VAL);
      changed_q <= 1'b0;
    end else begin
      target_q  <= target_next;
      value_q   <= value_next;
      changed_q <= (value_next != value_q);
    end
  end

  assign bus.target  = target_q;
  assign bus.value   = value_q;
  assign bus.changed = changed_q;

endmodule

// File: tb/tb_loop_param_selector.sv
// tb/tb_loop_param_selector.sv - directed self-checking bench for loop_param_selector
module tb_loop_param_selector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  loop_param_selector_if #(.VAL_W(3)) bus ();

  loop_param_selector #(
    .VAL_W         (3),
    .MIN_VAL       (2),
    .MAX_VAL       (6),
    .RESET_VAL     (3),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_key(input logic [8:0] code);
    bus.key_down[code] = 1'b1;
    bus.last_change    = code;
    bus.key_valid      = 1'b1;
    tick();
    bus.key_valid      = 1'b0;
  endtask

  task automatic release_key(input logic [8:0] code);
    bus.key_down[code] = 1'b0;
    bus.last_change    = code;
    bus.key_valid      = 1'b1;
    tick();
    bus.key_valid      = 1'b0;
  endtask

  task automatic tap_key(input logic [8:0] code);
    press_key(code);
    release_key(code);
  endtask

  initial begin
    bus.key_down      = '0;
    bus.last_change   = '0;
    bus.key_valid     = 1'b0;
    bus.loop_boundary = 1'b0;
    ticks(2);
    rst = 1'b0;
    tick();

    check("reset_value", bus.value, 3);
    check("reset_target", bus.target, 3);
    check("reset_pending", bus.pending, 0);
    check("reset_changed", bus.changed, 0);

`ifdef LOOP_PARAM_SYNC_EN
    press_key(9'h074);
    check("sync_target6", bus.target, 6);
    check("sync_value_held", bus.value, 3);
    check("sync_pending", bus.pending, 1);
    release_key(9'h074);
    bus.loop_boundary = 1'b1;
    tick();
    bus.loop_boundary = 1'b0;
    check("sync_commit", bus.value, 6);
    check("sync_pending_clr", bus.pending, 0);
    check("sync_changed", bus.changed, 1);
    tick();
    check("sync_changed_end", bus.changed, 0);
    tap_key(9'h073);
    bus.loop_boundary = 1'b1;
    press_key(9'h06B);
    bus.loop_boundary = 1'b0;
    check("sync_same_value", bus.value, 5);
    check("sync_same_target", bus.target, 4);
    check("sync_same_pending", bus.pending, 1);
    release_key(9'h06B);
`else
    press_key(9'h073);
    check("digit5_value", bus.value, 5);
    check("digit5_target", bus.target, 5);
    check("digit5_changed", bus.changed, 1);
    check("digit5_pending", bus.pending, 0);
    tick();
    check("digit5_changed_end", bus.changed, 0);
    release_key(9'h073);
    press_key(9'h07D);
    check("digit9_ignored", bus.target, 5);
    check("digit9_no_change", bus.changed, 0);
    release_key(9'h07D);
    bus.loop_boundary = 1'b1;
    tick();
    bus.loop_boundary = 1'b0;
    check("boundary_ignored", bus.value, 5);
    check("boundary_pending", bus.pending, 0);
`endif

    tap_key(9'h07A);
    check("digit3", bus.target, 3);

    press_key(9'h079);
    check("plus_press", bus.target, 4);
    ticks(7);
    check("plus_delay", bus.target, 4);
    tick();
    check("plus_rep1", bus.target, 5);
    ticks(3);
    check("plus_period", bus.target, 5);
    tick();
    check("plus_rep2", bus.target, 6);
    ticks(4);
    check("plus_sat", bus.target, 6);
`ifndef LOOP_PARAM_SYNC_EN
    check("plus_sat_value", bus.value, 6);
    check("plus_sat_changed", bus.changed, 0);
`endif
    release_key(9'h079);
    tap_key(9'h07A);
    ticks(12);
    check("idle_after_release", bus.target, 3);

    tap_key(9'h072);
    press_key(9'h07B);
    check("minus_sat", bus.target, 2);
    release_key(9'h07B);

    tap_key(9'h06B);
    press_key(9'h07B);
    check("minus_press", bus.target, 3);
    ticks(3);
    press_key(9'h079);
    check("switch_plus", bus.target, 4);
    ticks(7);
    check("no_extra_down", bus.target, 4);
    tick();
    check("delay_restart", bus.target, 5);
    release_key(9'h079);
    release_key(9'h07B);
    ticks(8);
    check("switch_idle", bus.target, 5);

    tap_key(9'h07A);
    press_key(9'h079);
    ticks(8);
    check("pre_rst_rep", bus.target, 5);
    ticks(2);
    #2;
    rst = 1'b1;
    #1;
    check("rst_value", bus.value, 3);
    check("rst_target", bus.target, 3);
    check("rst_pending", bus.pending, 0);
    check("rst_changed", bus.changed, 0);
    tick();
    rst = 1'b0;
    ticks(12);
    check("rst_no_step_target", bus.target, 3);
    check("rst_no_step_value", bus.value, 3);
    release_key(9'h079);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
